// File: rtl/gf2m_serial_mul_if.sv
// Requester <-> multiplier bundle for gf2m_serial_mul.
// The requester drives the operand strobe and operands; the multiplier
// returns the registered product, its one-cycle strobe and a busy flag.
interface gf2m_serial_mul_if #(
    parameter int M = 163
);
    logic         IN_VALID;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic         OUT_VALID;
    logic [M-1:0] C;
    logic         BUSY;

    modport master (
        output IN_VALID, A, B,
        input  OUT_VALID, C, BUSY
    );

    modport slave (
        input  IN_VALID, A, B,
        output OUT_VALID, C, BUSY
    );
endinterface

// File: rtl/gf2m_serial_mul.sv
// Bit-serial multiplier over GF(2^163), f(x) = x^163 + x^7 + x^6 + x^3 + 1,
// polynomial basis, MSB-first Horner evaluation over the bits of B.
// Default build consumes one bit of B per RUN cycle (M steps).
// Defining GF2M_MUL_DIGIT2_EN consumes two bits per cycle (ceil(M/2) steps),
// with B zero-extended by one bit so the digits pair up evenly.
// OUT_VALID is the DONE state; a new request is accepted in IDLE or DONE,
// so a requester answering OUT_VALID with IN_VALID runs back-to-back.
module gf2m_serial_mul #(
    parameter int M = 163
) (
    input logic              CLK,
    input logic              RST_N,
    gf2m_serial_mul_if.slave bus
);

`ifdef GF2M_MUL_DIGIT2_EN
    localparam int STEPS = (M + 1) / 2;
    localparam int BW    = M + 1;
`else
    localparam int STEPS = M;
    localparam int BW    = M;
`endif
    localparam int CW = $clog2(STEPS);

    // x^M folds back onto x^7 + x^6 + x^3 + 1
    localparam logic [M-1:0]  RED  = {{(M - 8){1'b0}}, 8'hC9};
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [M-1:0]  a_reg;
    logic [BW-1:0] b_reg;
    logic [M-1:0]  acc;
    logic [M-1:0]  acc_next;
    logic [M-1:0]  c_reg;
    logic [CW-1:0] cnt;
    logic          start;

    // Multiply a field element by x and reduce modulo f
    function automatic logic [M-1:0] mul_x(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? RED : '0);
    endfunction

    // Requests are taken whenever no multiplication is running
    assign start = bus.IN_VALID && (state != RUN);

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.IN_VALID) state_next = RUN;
            RUN:     if (cnt == '0) state_next = DONE;
            DONE:    state_next = bus.IN_VALID ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One Horner step on the current digit of B
    always_comb begin
`ifdef GF2M_MUL_DIGIT2_EN
        acc_next = mul_x(mul_x(acc))
                 ^ (b_reg[{cnt, 1'b1}] ? mul_x(a_reg) : '0)
                 ^ (b_reg[{cnt, 1'b0}] ? a_reg : '0);
`else
        acc_next = mul_x(acc) ^ (b_reg[cnt] ? a_reg : '0);
`endif
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    // Operand capture, accumulation and result register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            c_reg <= '0;
        end else if (start) begin
            a_reg <= bus.A;
`ifdef GF2M_MUL_DIGIT2_EN
            b_reg <= {1'b0, bus.B};
`else
            b_reg <= bus.B;
`endif
            acc   <= '0;
            cnt   <= LAST;
        end else if (state == RUN) begin
            acc <= acc_next;
            cnt <= cnt - ONE;
            if (cnt == '0) c_reg <= acc_next;
        end
    end

    assign bus.OUT_VALID = (state == DONE);
    assign bus.BUSY      = (state == RUN);
    assign bus.C         = c_reg;

endmodule

// File: doc/gf2m_serial_mul.md
GF2M_SERIAL_MUL -- requirements
Module: gf2m_serial_mul

Interface
REQ-001 The block SHALL have parameter M, default 163, meaning the field degree (fixed field GF(2^163)); reduction polynomial f(x)=x^163+x^7+x^6+x^3+1.
REQ-002 The block SHALL have port CLK  in  1  rising-edge clock.
REQ-003 The block SHALL have port RST_N  in  1  reset: synchronous, active-low, sampled on rising CLK.
REQ-004 The block SHALL have port IN_VALID  in  1  operand-valid strobe from the requester.
REQ-005 The block SHALL have port A  in  M  multiplicand, polynomial basis, bit i = coefficient of x^i.
REQ-006 The block SHALL have port B  in  M  multiplier, same encoding.
REQ-007 The block SHALL have port OUT_VALID  out  1  one-cycle result strobe.
REQ-008 The block SHALL have port C  out  M  product A*B mod f, registered.
REQ-009 The block SHALL have port BUSY  out  1  high while a multiplication is in progress.

Function
REQ-010 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 In IDLE or DONE with IN_VALID=1 at a rising edge, the block SHALL latch A and B, clear the accumulator, load the step counter, and enter RUN.
REQ-012 Each RUN cycle SHALL apply MSB-first: acc <= (acc*x mod f) XOR (B[i] ? A : 0), with i running from M-1 down to 0, and reduction folding bit M into bits 7, 6, 3 and 0.
REQ-013 After the final step, the block SHALL write acc to C, assert OUT_VALID for exactly one cycle in DONE, then go to IDLE, unless REQ-011 applies.
REQ-014 Latency: with 1 bit per step, OUT_VALID SHALL be high in the cycle beginning M+1 edges after the edge that sampled IN_VALID (164 for M=163).
REQ-015 IN_VALID in the DONE cycle SHALL be accepted, giving back-to-back operation with no idle cycle; the requester's next IN_VALID coincides with the observed OUT_VALID.
REQ-016 IN_VALID while in RUN SHALL be ignored: no operand relatch, no restart, and no effect on the current result.
REQ-017 BUSY SHALL equal (state==RUN).
REQ-018 C SHALL hold its value from the last completed multiplication until the next completion.
REQ-019 A and B SHALL be don't-care outside the IN_VALID sampling edge.
REQ-020 Operands with bits set at or above M cannot occur, because ports are exactly M wide; no reduction of inputs SHALL be performed.

Reset
REQ-021 With RST_N=0 at a rising edge, the block SHALL go to IDLE, set OUT_VALID=0, BUSY=0, C=0, and clear the accumulator, counter and operand registers.
REQ-022 Reset in RUN SHALL abort the operation with no OUT_VALID; IN_VALID in the first cycle after reset release SHALL be accepted normally.

Configuration
REQ-023 Macro GF2M_MUL_DIGIT2_EN: when defined, each RUN cycle SHALL process 2 bits of B (B zero-extended to M+1 bits, steps ceil(M/2)=82), acc <= (acc*x^2 mod f) XOR (B[i]·A·x) XOR (B[i-1]·A), and latency SHALL be 83 edges.
REQ-024 When GF2M_MUL_DIGIT2_EN is undefined, the block SHALL use 1 bit per cycle with 164-edge latency.
REQ-025 Results, handshake and reset behaviour SHALL be identical in both builds.

Verification
REQ-026 The bench SHALL cover: A=1, B=1 -> C=1, OUT_VALID one cycle at edge +164 (+83 digit-2); BUSY high for 163 (82) cycles.
REQ-027 The bench SHALL cover: A=x^162 (bit 162), B=x (0x2) -> C=0xC9 (x^7+x^6+x^3+1).
REQ-028 The bench SHALL cover: A=B=x^81 -> C=x^162; then A=random R, B=1 -> C=R.
REQ-029 The bench SHALL cover: IN_VALID asserted in the OUT_VALID cycle with new operands (x^162, x) -> second OUT_VALID exactly 164 (83) edges later with C=0xC9; first C is correct.
REQ-030 The bench SHALL cover: IN_VALID pulsed mid-RUN with different operands -> ignored; result matches the original operands.
REQ-031 The bench SHALL cover: RST_N=0 at step 50 of RUN -> next cycle C=0, OUT_VALID=0, BUSY=0; no stray OUT_VALID; new request completes correctly.
